in_port_fifo: RTL and testbench
===============================

# in_port_fifo

Multi-channel buffered input port for the datapath: the parametrised successor to the single-register strobe-loaded input port. Each of NUM_CH external devices loads WIDTH-bit words by pulsing its strobe; words queue in a per-channel FIFO of DEPTH entries. The selected channel's head word is driven onto the bus-mux input while InPortout is high, and is consumed when InPortout drops. Per-channel status flags are exposed for polling and interrupt logic.

## Interface
- WIDTH, 32, data word width (≥1)
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- NUM_CH, 2, number of input channels (≥1); SEL_W = max(1, clog2(NUM_CH))
- Clock  in  1  single clock, rising-edge active
- Clear  in  1  asynchronous, active-low reset
- InputDev  in  NUM_CH*WIDTH  device data; channel c occupies bits [c*WIDTH +: WIDTH]
- Strobe  in  NUM_CH  per-channel load strobe, level from device, may be asynchronous
- Sel  in  SEL_W  channel selected for bus read/status
- InPortout  in  1  bus drive enable; falling edge pops the selected channel
- FlagClr  in  1  clears sticky Overflow/Underflow of the selected channel
- BusMuxIn_InPort  out  WIDTH  head word of selected channel
- Empty  out  NUM_CH  per-channel FIFO empty
- Full  out  NUM_CH  per-channel FIFO full
- Overflow  out  NUM_CH  sticky: push attempted while full
- Underflow  out  NUM_CH  sticky: pop attempted while empty
- Count  out  clog2(DEPTH)+1  occupancy of selected channel

## Operation
- Push: one push per Strobe rising edge on channel c; InputDev slice for c captured at the push clock edge (device holds data stable from strobe rise until 3 clocks later).
- Pop: one pop per InPortout assertion, taken on the first Clock edge where InPortout=0 and previous sampled InPortout=1; channel = Sel sampled on that edge. Holding InPortout high for many cycles never pops more than once.
- BusMuxIn_InPort = head of FIFO[Sel] when InPortout=1 and FIFO[Sel] non-empty; all zeros otherwise (including empty). Combinational from Sel, InPortout and FIFO state.
- Full with push: word dropped, FIFO unchanged, Overflow[c] set.
- Empty with pop: no change, Underflow[Sel] set.
- Simultaneous push and pop same channel: if full, both succeed, count unchanged; if empty, push succeeds, pop flagged as underflow; otherwise both succeed.
- Pointers wrap modulo DEPTH; occupancy counter distinguishes full from empty.
- FlagClr high at a clock edge clears both flags of channel Sel; a set event in the same cycle wins.
- Sel ≥ NUM_CH: bus output zero, Count zero, pops and FlagClr ignored.

## Timing
- Clear low (asynchronous): all pointers, counts, flags, edge detectors and synchronizers cleared; Empty all ones, Full/Overflow/Underflow all zeros, Count 0, BusMuxIn_InPort 0. A strobe or read in progress at reset is discarded; a strobe still high after release does not push (detector resets to low and sees no rise until strobe returns low first is NOT required — detector state resets to 1-equivalent "seen high" only if strobe high at release; implement by resetting detector to 0 and masking the first cycle after release).
- Push latency (sync enabled): Strobe rises before edge k; push committed at edge k+2; Empty/Count updated after edge k+2.
- Pop latency: InPortout falls before edge k; pop committed at edge k; next head visible after edge k.
- Strobe minimum high and low time: 2 Clock periods each.

## Configuration
- INPORT_SYNC_EN defined: each Strobe passes through a two-flop synchronizer before edge detection; push at edge k+2 as above.
- INPORT_SYNC_EN undefined: Strobe sampled directly by the edge detector (device must be synchronous to Clock); push committed at edge k, the first edge seeing Strobe high.

## Test plan
- Reset then strobe ch0 with InputDev ch0 = 24, Sel=0, pulse InPortout 1 clock -> bus reads 24 while high; after fall Empty[0]=1, Count=0.
- Push 10,11,12,13 into ch1 (DEPTH=4), then 14 -> Full[1]=1, Overflow[1]=1, reads return 10,11,12,13 in order; FlagClr with Sel=1 clears Overflow[1].
- InPortout held high 5 clocks on ch0 holding 7,8 -> bus steady 7 entire time, exactly one pop, next read yields 8.
- Pop empty ch0 -> bus 0, Underflow[0]=1, Count stays 0; ch1 flags untouched.
- Full ch0: strobe push 99 on same edge as pop -> Count stays 4, 99 appears as 4th word after three more reads.
- Assert Clear mid-stream with ch0 count 3 and Strobe high -> all outputs at reset values immediately; no push after release until Strobe falls and rises again.

Source files
------------

// File: rtl/in_port_fifo.sv
// Multi-channel strobe-loaded input port with a per-channel FIFO, bus read/pop and sticky status flags.
// Optional INPORT_SYNC_EN: passes each Strobe through a two-flop synchronizer before edge detection.
module in_port_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 2
) (
    input  logic                                           Clock,
    input  logic                                           Clear,
    input  logic [NUM_CH*WIDTH-1:0]                        InputDev,
    input  logic [NUM_CH-1:0]                              Strobe,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] Sel,
    input  logic                                           InPortout,
    input  logic                                           FlagClr,
    output logic [WIDTH-1:0]                               BusMuxIn_InPort,
    output logic [NUM_CH-1:0]                              Empty,
    output logic [NUM_CH-1:0]                              Full,
    output logic [NUM_CH-1:0]                              Overflow,
    output logic [NUM_CH-1:0]                              Underflow,
    output logic [$clog2(DEPTH):0]                         Count
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [WIDTH-1:0]  mem    [NUM_CH][DEPTH];

    logic              inport_prev;
    logic              sel_ok;
    logic              pop_evt;
    logic              push_en;
    logic [1:0]        warm;
    logic [NUM_CH-1:0] strobe_src;
    logic [NUM_CH-1:0] strobe_prev;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] push_req;
    logic [NUM_CH-1:0] pop_req;
    logic [NUM_CH-1:0] push_ok;
    logic [NUM_CH-1:0] pop_ok;

`ifdef INPORT_SYNC_EN
    localparam int WARM = 3;
    logic [NUM_CH-1:0] strobe_p0;
    logic [NUM_CH-1:0] strobe_p1;

    // Stage p0/p1: metastability guard on the device strobes
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            strobe_p0 <= '0;
            strobe_p1 <= '0;
        end else begin
            strobe_p0 <= Strobe;
            strobe_p1 <= strobe_p0;
        end
    end
    assign strobe_src = strobe_p1;
`else
    localparam int WARM = 1;
    assign strobe_src = Strobe;
`endif

    // Pushes stay masked until the detector has seen the real strobe level,
    // so a strobe held high across reset release never loads a word.
    assign push_en  = (warm == 2'(WARM));
    assign push_req = strobe_src & ~strobe_prev & {NUM_CH{push_en}};

    always_comb begin
        sel_ok  = (32'(Sel) < NUM_CH);
        pop_evt = inport_prev & ~InPortout & sel_ok;
        sel_hit = '0;
        Empty   = '0;
        Full    = '0;
        pop_req = '0;
        push_ok = '0;
        pop_ok  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_hit[c] = sel_ok && (Sel == SEL_W'(c));
            Empty[c]   = (cnt[c] == '0);
            Full[c]    = (cnt[c] == CNT_W'(DEPTH));
            pop_req[c] = pop_evt & sel_hit[c];
            // A pop on the same edge frees the slot a full-FIFO push needs.
            push_ok[c] = push_req[c] & (~Full[c] | pop_req[c]);
            pop_ok[c]  = pop_req[c] & ~Empty[c];
        end
    end

    always_comb begin
        BusMuxIn_InPort = '0;
        Count           = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_hit[c]) begin
                Count = cnt[c];
                if (InPortout && !Empty[c]) begin
                    BusMuxIn_InPort = mem[c][rd_ptr[c]];
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            inport_prev <= 1'b0;
            strobe_prev <= '0;
            warm        <= '0;
            Overflow    <= '0;
            Underflow   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            inport_prev <= InPortout;
            strobe_prev <= strobe_src;
            if (!push_en) begin
                warm <= warm + 2'd1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_ok[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                end
                if (pop_ok[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                end
                cnt[c] <= cnt[c] + CNT_W'(push_ok[c]) - CNT_W'(pop_ok[c]);
                // Set events take priority over a same-cycle FlagClr.
                Overflow[c]  <= (push_req[c] & Full[c] & ~pop_req[c]) |
                                (Overflow[c] & ~(FlagClr & sel_hit[c]));
                Underflow[c] <= (pop_req[c] & Empty[c]) |
                                (Underflow[c] & ~(FlagClr & sel_hit[c]));
            end
        end
    end

    always_ff @(posedge Clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_ok[c]) begin
                mem[c][wr_ptr[c]] <= InputDev[c*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_in_port_fifo.sv
// Directed bench for in_port_fifo (default build): reference queues per channel predict bus words and status.
module tb_in_port_fifo;
    logic        Clock;
    logic        Clear;
    logic [63:0] InputDev;
    logic [1:0]  Strobe;
    logic [0:0]  Sel;
    logic        InPortout;
    logic        FlagClr;
    logic [31:0] BusMuxIn_InPort;
    logic [1:0]  Empty;
    logic [1:0]  Full;
    logic [1:0]  Overflow;
    logic [1:0]  Underflow;
    logic [2:0]  Count;

    in_port_fifo #(.WIDTH(32), .DEPTH(4), .NUM_CH(2)) dut (
        .Clock(Clock),
        .Clear(Clear),
        .InputDev(InputDev),
        .Strobe(Strobe),
        .Sel(Sel),
        .InPortout(InPortout),
        .FlagClr(FlagClr),
        .BusMuxIn_InPort(BusMuxIn_InPort),
        .Empty(Empty),
        .Full(Full),
        .Overflow(Overflow),
        .Underflow(Underflow),
        .Count(Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          pass_cnt;
    int          total_cnt;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [1:0]  m_ovf;
    logic [1:0]  m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int msize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] mhead(input int ch);
        if (ch == 0) return (q0.size() > 0) ? q0[0] : 32'd0;
        return (q1.size() > 0) ? q1[0] : 32'd0;
    endfunction

    task automatic m_push(input int ch, input logic [31:0] val);
        if (msize(ch) >= 4) m_ovf[ch] = 1'b1;
        else if (ch == 0) q0.push_back(val);
        else q1.push_back(val);
    endtask

    task automatic m_pop(input int ch);
        if (msize(ch) == 0) m_udf[ch] = 1'b1;
        else if (ch == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic m_reset();
        q0.delete();
        q1.delete();
        m_ovf = '0;
        m_udf = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_empty"}, 32'(Empty), 32'({msize(1) == 0, msize(0) == 0}));
        chk({tag, "_full"},  32'(Full),  32'({msize(1) == 4, msize(0) == 4}));
        chk({tag, "_ovf"},   32'(Overflow),  32'(m_ovf));
        chk({tag, "_udf"},   32'(Underflow), 32'(m_udf));
        chk({tag, "_count"}, 32'(Count), 32'(msize(int'(Sel))));
    endtask

    task automatic do_strobe(input int ch, input logic [31:0] val);
        @(negedge Clock);
        InputDev[ch*32 +: 32] = val;
        Strobe[ch] = 1'b1;
        m_push(ch, val);
        repeat (2) @(negedge Clock);
        Strobe[ch] = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic do_read(input int ch, input string tag);
        @(negedge Clock);
        Sel = 1'(ch);
        #1 chk({tag, "_idle_bus"}, BusMuxIn_InPort, 32'd0);
        InPortout = 1'b1;
        #1 chk({tag, "_bus"}, BusMuxIn_InPort, mhead(ch));
        @(negedge Clock);
        InPortout = 1'b0;
        @(negedge Clock);
        m_pop(ch);
        check_all(tag);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        m_reset();
        Clear     = 1'b0;
        InputDev  = '0;
        Strobe    = '0;
        Sel       = '0;
        InPortout = 1'b0;
        FlagClr   = 1'b0;

        // Reset state
        repeat (2) @(negedge Clock);
        check_all("rst");
        InPortout = 1'b1;
        #1 chk("rst_bus", BusMuxIn_InPort, 32'd0);
        InPortout = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        repeat (2) @(negedge Clock);

        // Single word through channel 0
        do_strobe(0, 32'd24);
        check_all("p24");
        do_read(0, "r24");

        // Channel 1 fill, overflow, drain in order, flag clear
        for (int i = 10; i <= 14; i++) do_strobe(1, 32'(i));
        Sel = 1'b1;
        #1 check_all("c1full");
        for (int i = 0; i < 4; i++) do_read(1, "c1rd");
        @(negedge Clock);
        Sel = 1'b1;
        FlagClr = 1'b1;
        @(negedge Clock);
        FlagClr = 1'b0;
        m_ovf[1] = 1'b0;
        check_all("fclr");

        // Long InPortout pulse pops exactly once
        do_strobe(0, 32'd7);
        do_strobe(0, 32'd8);
        @(negedge Clock);
        Sel = 1'b0;
        InPortout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_bus", BusMuxIn_InPort, 32'd7);
            chk("hold_count", 32'(Count), 32'd2);
            @(negedge Clock);
        end
        InPortout = 1'b0;
        @(negedge Clock);
        m_pop(0);
        check_all("hold_pop");
        do_read(0, "r8");

        // Pop of an empty channel
        do_read(0, "uflow");

        // Push and pop on the same edge while full
        for (int i = 1; i <= 4; i++) do_strobe(0, 32'(i));
        check_all("c0full");
        @(negedge Clock);
        Sel = 1'b0;
        InPortout = 1'b1;
        #1 chk("simul_head", BusMuxIn_InPort, 32'd1);
        @(negedge Clock);
        InputDev[31:0] = 32'd99;
        Strobe[0] = 1'b1;
        InPortout = 1'b0;
        m_pop(0);
        m_push(0, 32'd99);
        @(negedge Clock);
        chk("simul_count", 32'(Count), 32'd4);
        check_all("simul");
        Strobe[0] = 1'b0;
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 4; i++) do_read(0, "simul_rd");

        // Asynchronous Clear mid-stream with a strobe high
        for (int i = 40; i < 43; i++) do_strobe(0, 32'(i));
        chk("pre_clr_count", 32'(Count), 32'd3);
        @(negedge Clock);
        InputDev[31:0] = 32'd55;
        Strobe[0] = 1'b1;
        InPortout = 1'b1;
        #2 Clear = 1'b0;
        m_reset();
        #1 check_all("clr");
        chk("clr_bus", BusMuxIn_InPort, 32'd0);
        InPortout = 1'b0;
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        repeat (4) @(negedge Clock);
        check_all("post_clr");
        Strobe[0] = 1'b0;
        repeat (2) @(negedge Clock);
        do_strobe(0, 32'd66);
        check_all("re_push");
        do_read(0, "r66");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
